coef_fetch: RTL and testbench
=============================

COEF_FETCH -- requirements
Module: coef_fetch

Interface
REQ-001 Parameter: ADDR_W, 8, ROM address width.
REQ-002 Parameter: DATA_W, 48, ROM word width.
REQ-003 Parameter: READ_LAT, 2, cycles from rom_ce_o high to valid rom_dout_i (address register plus output register with oce high).
REQ-004 Port: clk  input  1  single clock; all logic rising-edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start_i  input  1  one-cycle request to begin a burst.
REQ-007 Port: base_i  input  ADDR_W  first ROM address, sampled on accepted start.
REQ-008 Port: count_i  input  ADDR_W+1  number of words to read, sampled on accepted start.
REQ-009 Port: busy_o  output  1  high from accepted start until the burst completes.
REQ-010 Port: done_o  output  1  one-cycle pulse at burst completion.
REQ-011 Port: rom_ce_o  output  1  ROM read enable, one pulse per word.
REQ-012 Port: rom_oce_o  output  1  ROM output-register enable.
REQ-013 Port: rom_ad_o  output  ADDR_W  ROM address.
REQ-014 Port: rom_dout_i  input  DATA_W  ROM read data.
REQ-015 Port: coef_o  output  DATA_W  coefficient to consumer.
REQ-016 Port: coef_valid_o  output  1  coef_o valid.
REQ-017 Port: coef_ready_i  input  1  consumer accepts; transfer when valid and ready are both high.
REQ-018 Port: coef_last_o  output  1  marks the final word of a burst; qualified by coef_valid_o.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, DRAIN.
- IDLE to FETCH on start_i with count_i>0.
- FETCH to DRAIN after the last read is issued.
- DRAIN to IDLE on the handshake of the word carrying coef_last_o.
REQ-020 If start_i arrives in IDLE with count_i=0, the FSM SHALL stay in IDLE, leave busy_o low, and pulse done_o on the next cycle.
REQ-021 start_i SHALL be ignored while busy_o is high.
REQ-022 Read k (k=0..count-1) SHALL drive rom_ad_o = (base + k) mod 2^ADDR_W, so addresses wrap past the top of the ROM.
REQ-023 rom_oce_o SHALL be high whenever busy_o is high and low otherwise; rom_ce_o SHALL be low outside FETCH.
REQ-024 Returning data SHALL be captured READ_LAT cycles after the corresponding rom_ce_o into a show-ahead FIFO of depth READ_LAT+2.
REQ-025 Flow control: a read SHALL be issued only when (reads in flight + FIFO occupancy) < READ_LAT+2, so the FIFO never overflows.
REQ-026 Latency: first rom_ce_o SHALL occur 1 cycle after the start cycle, and the first coef_valid_o SHALL occur READ_LAT+2 cycles after the start cycle.
REQ-027 With coef_ready_i held high, throughput SHALL be one word per cycle with no gaps.
REQ-028 coef_o and coef_last_o SHALL remain stable while coef_valid_o is high and coef_ready_i is low.
REQ-029 Words SHALL be delivered in address order, exactly count words per burst.
REQ-030 done_o SHALL pulse on the cycle after the last handshake; busy_o SHALL fall in that same cycle.

Reset
REQ-031 While reset is high, asynchronously:
- FSM to IDLE; FIFO and in-flight counters empty.
- busy_o, done_o, rom_ce_o, rom_oce_o, coef_valid_o, coef_last_o = 0.
- rom_ad_o = 0; coef_o = 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst, with no done_o pulse; the first start_i after reset release SHALL be accepted normally.

Configuration
REQ-033 Macro COEF_FETCH_CHECKSUM_EN defined: add output checksum_o (DATA_W bits) = sum mod 2^DATA_W of all words handshaken in the current burst.
- Cleared to 0 on accepted start and on reset.
- Final value valid when done_o is high and held until the next start.
REQ-034 Macro COEF_FETCH_CHECKSUM_EN undefined: no checksum_o port and no checksum logic; all other behaviour identical.

Verification
REQ-035 Ready held high, base=0, count=4 -> rom_ad_o reads 0,1,2,3 on consecutive cycles; first valid at start+4; 4 back-to-back words; coef_last_o on word 4; done_o the cycle after.
REQ-036 base=254, count=4, ADDR_W=8 -> addresses 254,255,0,1 in order.
REQ-037 count=16, coef_ready_i toggling 1 cycle high / 3 cycles low -> no lost or duplicated words, data stable while stalled, and in-flight plus occupancy never exceeds 4.
REQ-038 start_i with count=0 -> no rom_ce_o, busy_o stays 0, done_o pulses once; start_i pulsed mid-burst -> ignored, exactly the original count delivered.
REQ-039 reset asserted on the 3rd word of a count=8 burst -> all outputs 0 immediately, no done_o; a new burst with count=2 then completes correctly.
REQ-040 With COEF_FETCH_CHECKSUM_EN, ROM words 1,2,3 at addresses 0..2, count=3 -> checksum_o = 6 when done_o is high.

Source files
------------

// File: rtl/coef_fetch_if.sv
// coef_fetch_if: request, ROM-side and coefficient-stream signals of coef_fetch.
// checksum_o is present only when COEF_FETCH_CHECKSUM_EN is defined.
interface coef_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 48
);
    logic              start_i;
    logic [ADDR_W-1:0] base_i;
    logic [ADDR_W:0]   count_i;
    logic              busy_o;
    logic              done_o;
    logic              rom_ce_o;
    logic              rom_oce_o;
    logic [ADDR_W-1:0] rom_ad_o;
    logic [DATA_W-1:0] rom_dout_i;
    logic [DATA_W-1:0] coef_o;
    logic              coef_valid_o;
    logic              coef_ready_i;
    logic              coef_last_o;
`ifdef COEF_FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_o;

    modport slave (
        input  start_i, base_i, count_i, rom_dout_i, coef_ready_i,
        output busy_o, done_o, rom_ce_o, rom_oce_o, rom_ad_o,
        output coef_o, coef_valid_o, coef_last_o, checksum_o
    );
    modport master (
        output start_i, base_i, count_i, rom_dout_i, coef_ready_i,
        input  busy_o, done_o, rom_ce_o, rom_oce_o, rom_ad_o,
        input  coef_o, coef_valid_o, coef_last_o, checksum_o
    );
`else
    modport slave (
        input  start_i, base_i, count_i, rom_dout_i, coef_ready_i,
        output busy_o, done_o, rom_ce_o, rom_oce_o, rom_ad_o,
        output coef_o, coef_valid_o, coef_last_o
    );
    modport master (
        output start_i, base_i, count_i, rom_dout_i, coef_ready_i,
        input  busy_o, done_o, rom_ce_o, rom_oce_o, rom_ad_o,
        input  coef_o, coef_valid_o, coef_last_o
    );
`endif
endinterface

// File: rtl/coef_fetch.sv
// coef_fetch: reads a burst of words from a READ_LAT-cycle ROM into a show-ahead FIFO.
// Defining COEF_FETCH_CHECKSUM_EN adds checksum_o, the running sum of delivered words.
module coef_fetch #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 48,
    parameter int READ_LAT = 2
) (
    input logic         clk,
    input logic         reset,
    coef_fetch_if.slave bus
);
    localparam int DEPTH = READ_LAT + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]       remain;
    logic [CNT_W-1:0]    committed;
    logic [CNT_W-1:0]    occ;
    logic                issue, issue_last, accept;
    logic                pop, pop_last, room, cap, cap_last;
    logic [READ_LAT-1:0] vld_p, last_p;
    logic                ce_last;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic                last_mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic dec);
        return c + CNT_W'(inc) - CNT_W'(dec);
    endfunction

    // committed = reads in flight + FIFO occupancy; never allowed past DEPTH
    assign pop      = bus.coef_valid_o & bus.coef_ready_i;
    assign pop_last = pop & bus.coef_last_o;
    assign room     = (committed != CNT_W'(DEPTH)) | pop;
    assign cap      = vld_p[READ_LAT-1];
    assign cap_last = last_p[READ_LAT-1];

    assign bus.busy_o       = (state != IDLE);
    assign bus.rom_oce_o    = bus.busy_o;
    assign bus.coef_valid_o = (occ != '0);
    assign bus.coef_o       = bus.coef_valid_o ? data_mem[rd_ptr] : '0;
    assign bus.coef_last_o  = bus.coef_valid_o & last_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept = 1'b1;
                    if (bus.count_i != '0) begin
                        issue      = 1'b1;
                        issue_last = (bus.count_i == CW'(1));
                        state_nxt  = FETCH;
                    end
                end
            end
            FETCH: begin
                // leave only once the final rom_ce_o pulse has been driven
                if (remain == '0) begin
                    state_nxt = DRAIN;
                end else if (room) begin
                    issue      = 1'b1;
                    issue_last = (remain == CW'(1));
                end
            end
            DRAIN: begin
                if (pop_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0..p(READ_LAT-1): track each read through the ROM pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remain       <= '0;
            committed    <= '0;
            occ          <= '0;
            vld_p        <= '0;
            last_p       <= '0;
            ce_last      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.rom_ce_o <= 1'b0;
            bus.rom_ad_o <= '0;
            bus.done_o   <= 1'b0;
        end else begin
            bus.rom_ce_o <= issue;
            ce_last      <= issue_last;
            if (issue)
                bus.rom_ad_o <= (state == IDLE) ? bus.base_i : bus.rom_ad_o + ADDR_W'(1);
            if (accept)     remain <= bus.count_i - CW'(issue);
            else if (issue) remain <= remain - CW'(1);
            committed <= cnt_upd(committed, issue, pop);
            occ       <= cnt_upd(occ, cap, pop);
            vld_p[0]  <= bus.rom_ce_o;
            last_p[0] <= ce_last;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
            if (cap) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            bus.done_o <= ((state == DRAIN) && pop_last) ||
                          ((state == IDLE) && bus.start_i && (bus.count_i == '0));
        end
    end

    // FIFO capture of returning ROM data
    always_ff @(posedge clk) begin
        if (cap) begin
            data_mem[wr_ptr] <= bus.rom_dout_i;
            last_mem[wr_ptr] <= cap_last;
        end
    end

`ifdef COEF_FETCH_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       bus.checksum_o <= '0;
        else if (accept) bus.checksum_o <= '0;
        else if (pop)    bus.checksum_o <= bus.checksum_o + bus.coef_o;
    end
`endif
endmodule

// File: tb/tb_coef_fetch.sv
// tb_coef_fetch: randomized bursts against a ROM model; a scoreboard checks addresses,
// delivered words, stall stability, done timing and the outstanding-read bound.
module tb_coef_fetch;
    localparam int AW = 8;
    localparam int DW = 48;

    logic Fg_CLK_tb;
    logic reset;

    coef_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    coef_fetch #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) dut (
        .clk   (Fg_CLK_tb),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int zero_done_cyc = -1;

    logic [DW-1:0] rom [256];
    logic [AW-1:0] rom_aq;
    logic [DW-1:0] rom_dq;

    int            addr_q [$];
    logic [DW:0]   word_q [$];

    initial begin
        Fg_CLK_tb = 1'b0;
        forever #5 Fg_CLK_tb = ~Fg_CLK_tb;
    end

    initial forever begin
        @(posedge Fg_CLK_tb);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 60000", cyc);
        $fatal(1);
    end

    // ROM: address register on ce, output register on oce
    always @(posedge Fg_CLK_tb) begin
        if (bus.rom_ce_o)  rom_aq <= bus.rom_ad_o;
        if (bus.rom_oce_o) rom_dq <= rom[rom_aq];
    end
    assign bus.rom_dout_i = rom_dq;

    initial forever begin
        @(posedge Fg_CLK_tb);
        #1;
        case (rdy_mode)
            0:       bus.coef_ready_i = 1'b1;
            1:       bus.coef_ready_i = 1'($urandom_range(0, 1));
            default: bus.coef_ready_i = (cyc % 4 == 0);
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    int          ce_cnt = 0, hs_cnt = 0, exp_done_cyc = -1;
    bit          prev_stall = 1'b0;
    logic [DW:0] held, exp_w;
    int          exp_a;

    always @(negedge Fg_CLK_tb) begin
        if (reset) begin
            addr_q.delete();
            word_q.delete();
            prev_stall   = 1'b0;
            ce_cnt       = 0;
            hs_cnt       = 0;
            exp_done_cyc = -1;
        end else begin
            if (bus.rom_ce_o) begin
                ce_cnt++;
                if (addr_q.size() == 0) begin
                    chk("unexpected_rom_ce", 1, 0);
                end else begin
                    exp_a = addr_q.pop_front();
                    chk("rom_ad", 64'(bus.rom_ad_o), 64'(exp_a));
                end
                chk("outstanding_le_4", 64'(ce_cnt - hs_cnt <= 4), 1);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.coef_valid_o, 1);
                chk("stall_data", {bus.coef_last_o, bus.coef_o}, held);
            end
            if (bus.coef_valid_o && bus.coef_ready_i) begin
                if (word_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    exp_w = word_q.pop_front();
                    chk("coef", bus.coef_o, exp_w[DW-1:0]);
                    chk("coef_last", bus.coef_last_o, exp_w[DW]);
                    if (exp_w[DW]) exp_done_cyc = cyc + 1;
                end
                hs_cnt++;
            end
            if (bus.done_o || cyc == exp_done_cyc || cyc == zero_done_cyc) begin
                chk("done_timing", bus.done_o, (cyc == exp_done_cyc || cyc == zero_done_cyc));
                chk("busy_at_done", bus.busy_o, 0);
            end
            prev_stall = bus.coef_valid_o && !bus.coef_ready_i;
            held       = {bus.coef_last_o, bus.coef_o};
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_done"}, bus.done_o, 0);
        chk({tag, "_ce"}, bus.rom_ce_o, 0);
        chk({tag, "_oce"}, bus.rom_oce_o, 0);
        chk({tag, "_valid"}, bus.coef_valid_o, 0);
        chk({tag, "_last"}, bus.coef_last_o, 0);
        chk({tag, "_ad"}, bus.rom_ad_o, 0);
        chk({tag, "_coef"}, bus.coef_o, 0);
    endtask

    // Reference model: word k of a burst is rom[(base+k) mod 256]; last flag on k=cnt-1
    function automatic logic [DW-1:0] push_burst(input int base, input int cnt);
        logic [DW-1:0] sum = '0;
        for (int k = 0; k < cnt; k++) begin
            addr_q.push_back((base + k) % 256);
            word_q.push_back({(k == cnt - 1), rom[(base + k) % 256]});
            sum += rom[(base + k) % 256];
        end
        return sum;
    endfunction

    task automatic run_burst(input int base, input int cnt, input int mode, input bit inject);
        int s, lat, fh, lh;
        bit seen;
        logic [DW-1:0] exp_sum;
        rdy_mode = mode;
        @(posedge Fg_CLK_tb);
        #1;
        exp_sum = push_burst(base, cnt);
        bus.start_i = 1'b1;
        bus.base_i  = AW'(base);
        bus.count_i = (AW + 1)'(cnt);
        s = cyc;
        @(negedge Fg_CLK_tb);
        chk("ce_before_lat", bus.rom_ce_o, 0);
        @(posedge Fg_CLK_tb);
        #1;
        bus.start_i = 1'b0;
        @(negedge Fg_CLK_tb);
        chk("first_ce_lat", bus.rom_ce_o, 1);
        chk("busy_in_burst", bus.busy_o, 1);
        chk("oce_in_burst", bus.rom_oce_o, 1);
        lat = -1; fh = -1; lh = -1; seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (bus.coef_valid_o && lat < 0) lat = cyc - s;
            if (bus.coef_valid_o && bus.coef_ready_i) begin
                if (fh < 0) fh = cyc;
                lh = cyc;
            end
            if (bus.done_o) begin
                seen = 1'b1;
                break;
            end
            if (inject) begin
                bus.start_i = (i == 6);
                bus.base_i  = AW'($urandom_range(0, 255));
                bus.count_i = 5;
            end
            @(negedge Fg_CLK_tb);
        end
        bus.start_i = 1'b0;
        chk("done_seen", 64'(seen), 1);
        chk("first_valid_lat", 64'(lat), 4);
        chk("words_drained", 64'(word_q.size()), 0);
        chk("addrs_drained", 64'(addr_q.size()), 0);
        chk("oce_after_done", bus.rom_oce_o, 0);
        if (mode == 0) chk("gapless", 64'(lh - fh), 64'(cnt - 1));
`ifdef COEF_FETCH_CHECKSUM_EN
        chk("checksum", bus.checksum_o, exp_sum);
`else
        if (exp_sum == '1) $display("note: all-ones burst sum");
`endif
    endtask

    task automatic zero_count();
        @(posedge Fg_CLK_tb);
        #1;
        bus.start_i   = 1'b1;
        bus.base_i    = AW'($urandom_range(0, 255));
        bus.count_i   = '0;
        zero_done_cyc = cyc + 1;
        @(posedge Fg_CLK_tb);
        #1;
        bus.start_i = 1'b0;
        @(negedge Fg_CLK_tb);
        chk("zero_done", bus.done_o, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Fg_CLK_tb);
            chk("zero_busy", bus.busy_o, 0);
            chk("zero_ce", bus.rom_ce_o, 0);
        end
    endtask

    task automatic reset_mid();
        int  n;
        bit  ok;
        logic [DW-1:0] unused_sum;
        rdy_mode = 0;
        @(posedge Fg_CLK_tb);
        #1;
        unused_sum = push_burst(40, 8);
        bus.start_i = 1'b1;
        bus.base_i  = 40;
        bus.count_i = 8;
        @(posedge Fg_CLK_tb);
        #1;
        bus.start_i = 1'b0;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Fg_CLK_tb);
            if (bus.coef_valid_o && bus.coef_ready_i) n++;
            if (n == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reset_reach_word3", 64'(ok), 1);
        @(posedge Fg_CLK_tb);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        @(posedge Fg_CLK_tb);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Fg_CLK_tb);
            chk("no_done_after_abort", bus.done_o, 0);
            chk("idle_after_abort", bus.busy_o, 0);
        end
    endtask

    initial begin
        logic [63:0] r;
        reset            = 1'b1;
        bus.start_i      = 1'b0;
        bus.base_i       = '0;
        bus.count_i      = '0;
        bus.coef_ready_i = 1'b1;
        for (int a = 0; a < 256; a++) begin
            r = {$urandom(), $urandom()};
            rom[a] = r[DW-1:0];
        end
        #1;
        chk_zero("reset");
        repeat (3) @(posedge Fg_CLK_tb);
        #1;
        reset = 1'b0;

        run_burst(0, 4, 0, 1'b0);
        run_burst(254, 4, 0, 1'b0);
        run_burst($urandom_range(0, 255), 16, 2, 1'b0);
        zero_count();
        run_burst($urandom_range(0, 255), 12, 0, 1'b1);
        reset_mid();
        run_burst($urandom_range(0, 255), 2, 0, 1'b0);

        rom[0] = 1; rom[1] = 2; rom[2] = 3;
        run_burst(0, 3, 0, 1'b0);
`ifdef COEF_FETCH_CHECKSUM_EN
        chk("checksum_123", bus.checksum_o, 6);
`endif
        for (int t = 0; t < 10; t++)
            run_burst($urandom_range(0, 255), $urandom_range(1, 20), $urandom_range(0, 2), 1'b0);
        run_burst($urandom_range(0, 255), 256, 1, 1'b0);

        repeat (5) @(negedge Fg_CLK_tb);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
